uart_cmd_wrapper: RTL

Command framing stage between the host-side UART receiver/transmitter and the command dispatcher of `DSO_dig`. It assembles three consecutive received UART bytes into one 24-bit command word and presents it with a ready flag until the dispatcher consumes it. It also serialises single-byte responses (0xA5 ack, read data) back into the UART transmitter. An inter-byte timeout resynchronises the framer if a partial command is abandoned.

---
 rtl/dso_pkg.sv | 33 +++
 rtl/uart_cmd_wrapper.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dso_pkg.sv
// Shared definitions for the DSO_dig host command path: framer/transmitter
// FSM state encodings and the dispatcher's command opcodes.
package dso_pkg;

    // Receive framer states: waiting for byte 1, 2, 3, or holding a full command
    typedef enum logic [1:0] {
        B1   = 2'd0,
        B2   = 2'd1,
        B3   = 2'd2,
        FULL = 2'd3
    } rx_state_t;

    // Response transmitter states
    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    // Command opcodes carried in cmd[23:16]
    localparam logic [7:0] DUMP_CH  = 8'h01;
    localparam logic [7:0] CFG_GAIN = 8'h02;
    localparam logic [7:0] TRIG_LVL = 8'h03;
    localparam logic [7:0] TRIG_POS = 8'h04;
    localparam logic [7:0] SET_DEC  = 8'h05;
    localparam logic [7:0] TRIG_CFG = 8'h06;
    localparam logic [7:0] TRIG_RD  = 8'h07;
    localparam logic [7:0] EEP_WR   = 8'h08;
    localparam logic [7:0] EEP_RD   = 8'h09;

    // Positive acknowledge byte returned to the host
    localparam logic [7:0] POS_ACK  = 8'hA5;

endpackage

// File: rtl/uart_cmd_wrapper.sv
// Command framing stage between the host UART and the command dispatcher.
// Three received bytes form one 24-bit command (first byte in the MSBs).
// A stalled partial frame is dropped after TIMEOUT idle cycles so the framer
// resynchronises. Single-byte responses are handed to the UART transmitter
// and their completion is reported back to the dispatcher.
module uart_cmd_wrapper
    import dso_pkg::*;
#(
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp_data,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        frame_err
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    // Receive side state
    rx_state_t          rx_state_q;
    logic [CW-1:0]      tmo_cnt_q;
    logic [23:0]        cmd_q;
    logic               cmd_rdy_q;
    logic               frame_err_q;

    // Transmit side state
    tx_state_t          tx_state_q;
    logic [7:0]         tx_data_q;
    logic               trmt_pend_q;
    logic               trmt_q;
    logic               tx_done_q;
    logic               resp_sent_q;

    logic               rx_accept_s;
    logic               tmo_hit_s;

    // Byte acceptance: any framing state except FULL takes a pending byte;
    // the timeout fires on the cycle the counter would reach TIMEOUT.
    always_comb begin
        rx_accept_s = 1'b0;
        tmo_hit_s   = 1'b0;
        if (rx_rdy && (rx_state_q != FULL)) begin
            rx_accept_s = 1'b1;
        end else begin
            rx_accept_s = 1'b0;
        end
        if (tmo_cnt_q == TMO_LAST) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Receive framer: collect three bytes, hold the command until consumed,
    // and discard a partial frame when the inter-byte gap runs out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= B1;
            tmo_cnt_q   <= CNT_ZERO;
            cmd_q       <= 24'h00_0000;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (rx_state_q)
                B1: begin
                    tmo_cnt_q <= CNT_ZERO;
                    if (rx_rdy) begin
                        cmd_q[23:16] <= rx_data;
                        rx_state_q   <= B2;
                    end
                end
                B2: begin
                    if (rx_rdy) begin
                        cmd_q[15:8] <= rx_data;
                        tmo_cnt_q   <= CNT_ZERO;
                        rx_state_q  <= B3;
                    end else if (tmo_hit_s) begin
                        tmo_cnt_q   <= CNT_ZERO;
                        frame_err_q <= 1'b1;
                        rx_state_q  <= B1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_ONE;
                    end
                end
                B3: begin
                    if (rx_rdy) begin
                        cmd_q[7:0] <= rx_data;
                        tmo_cnt_q  <= CNT_ZERO;
                        cmd_rdy_q  <= 1'b1;
                        rx_state_q <= FULL;
                    end else if (tmo_hit_s) begin
                        tmo_cnt_q   <= CNT_ZERO;
                        frame_err_q <= 1'b1;
                        rx_state_q  <= B1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_ONE;
                    end
                end
                FULL: begin
                    // New bytes wait in the UART until the dispatcher is done
                    tmo_cnt_q <= CNT_ZERO;
                    if (clr_cmd_rdy) begin
                        cmd_rdy_q  <= 1'b0;
                        rx_state_q <= B1;
                    end
                end
                default: begin
                    tmo_cnt_q  <= CNT_ZERO;
                    cmd_rdy_q  <= 1'b0;
                    rx_state_q <= B1;
                end
            endcase
        end
    end

    // Response transmitter: latch the byte, fire trmt one cycle later,
    // then wait for the rising edge of tx_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_data_q   <= 8'h00;
            trmt_pend_q <= 1'b0;
            trmt_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            tx_done_q   <= tx_done;
            trmt_q      <= trmt_pend_q;
            trmt_pend_q <= 1'b0;
            resp_sent_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (send_resp) begin
                        tx_data_q   <= resp_data;
                        trmt_pend_q <= 1'b1;
                        tx_state_q  <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    // send_resp is ignored here: only one response is ever outstanding
                    if (tx_done && !tx_done_q) begin
                        resp_sent_q <= 1'b1;
                        tx_state_q  <= TX_IDLE;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign clr_rx_rdy = rx_accept_s;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign frame_err  = frame_err_q;
    assign trmt       = trmt_q;
    assign tx_data    = tx_data_q;
    assign resp_sent  = resp_sent_q;

endmodule
